pipe_stage_reg: RTL and testbench

// - Parametrised inter-stage pipeline register (IF/DE, DE/EX, ...) for the CPU pipeline.
// - Carries LANES payload words of DATA_W bits each, plus a valid bit.
// - Supports hazard-unit stall (active-low enable) and branch-unit flush (clrBU).
// - Counts consecutive stall cycles and raises a timeout flag for hang detection.

---
 rtl/pipe_stage_reg.sv | 144 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: LANES payload words plus a valid bit, with
// hazard stall (active-low enable), branch flush (clrBU), a saturating
// consecutive-stall counter and timeout flag for hang detection.
// Optional feature macro: PIPE_STAGE_PERF_EN adds saturating 32-bit totals of
// stall and flush cycles; without it perf_stalls/perf_flushes are tied to 0.

// One payload lane. Flush and bubble both load the flush pattern so a killed
// slot looks like a NOP to the downstream stage.
module pipe_stage_lane #(
    parameter int                 DATA_W  = 32,
    parameter logic [DATA_W-1:0]  RST_V   = '0,
    parameter logic [DATA_W-1:0]  FLUSH_V = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              load,
    input  logic              bubble,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Lane register: flush or bubble beats capture; otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 q <= RST_V;
        else if (flush || bubble) q <= FLUSH_V;
        else if (load)           q <= d;
    end

endmodule

module pipe_stage_reg #(
    parameter int          DATA_W      = 32,
    parameter int          LANES       = 2,
    parameter logic [31:0] RESET_VAL   = 32'h0,
    parameter logic [31:0] FLUSH_VAL   = 32'h0,
    parameter int          CNT_W       = 8,
    parameter int          STALL_LIMIT = 200
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    clrBU,
    input  logic                    in_valid,
    input  logic [LANES*DATA_W-1:0] data_in,
    output logic [LANES*DATA_W-1:0] data_out,
    output logic                    out_valid,
    output logic [CNT_W-1:0]        stall_cycles,
    output logic                    stall_timeout,
    output logic [31:0]             perf_stalls,
    output logic [31:0]             perf_flushes
);

    localparam logic [DATA_W-1:0] RST_LANE   = DATA_W'(RESET_VAL);
    localparam logic [DATA_W-1:0] FLUSH_LANE = DATA_W'(FLUSH_VAL);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    // A limit the counter can never reach would silently disable hang detection.
    if (longint'(STALL_LIMIT) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_limit
        $error("pipe_stage_reg: STALL_LIMIT %0d exceeds stall counter range (CNT_W=%0d)",
               STALL_LIMIT, CNT_W);
    end

    // Decoded per-edge action, priority flush > hold > load.
    typedef struct packed {
        logic flush;   // branch kill
        logic load;    // capture a real instruction
        logic bubble;  // capture with no upstream instruction
        logic hold;    // stall: keep contents
    } ctrl_t;

    ctrl_t ctrl;

    // Resolve the control priority once so every lane sees the same decision.
    always_comb begin
        ctrl        = '0;
        ctrl.flush  = clrBU;
        ctrl.hold   = !clrBU && enable;
        ctrl.load   = !clrBU && !enable && in_valid;
        ctrl.bubble = !clrBU && !enable && !in_valid;
    end

    logic [LANES-1:0][DATA_W-1:0] din_l;
    logic [LANES-1:0][DATA_W-1:0] dout_l;

    assign din_l    = data_in;
    assign data_out = dout_l;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        pipe_stage_lane #(
            .DATA_W  (DATA_W),
            .RST_V   (RST_LANE),
            .FLUSH_V (FLUSH_LANE)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .flush  (ctrl.flush),
            .load   (ctrl.load),
            .bubble (ctrl.bubble),
            .d      (din_l[k]),
            .q      (dout_l[k])
        );
    end

    // Valid bit: set only by a real load, cleared by flush or bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           out_valid <= 1'b0;
        else if (ctrl.flush || ctrl.bubble) out_valid <= 1'b0;
        else if (ctrl.load)                out_valid <= 1'b1;
    end

    // Consecutive stall counter; a held bubble is not a stall, and the count
    // saturates so a long hang never wraps back below the timeout limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          stall_cycles <= '0;
        else if (!ctrl.hold || !out_valid) stall_cycles <= '0;
        else if (stall_cycles != CNT_MAX)  stall_cycles <= stall_cycles + 1'b1;
    end

    if (STALL_LIMIT == 0) begin : g_no_timeout
        assign stall_timeout = 1'b0;
    end else begin : g_timeout
        localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);
        assign stall_timeout = (stall_cycles >= LIMIT);
    end

`ifdef PIPE_STAGE_PERF_EN
    // Lifetime stall total; only cleared by reset, sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         perf_stalls <= '0;
        else if (ctrl.hold && out_valid && !(&perf_stalls)) perf_stalls <= perf_stalls + 32'd1;
    end

    // Lifetime flush total; only cleared by reset, sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 perf_flushes <= '0;
        else if (ctrl.flush && !(&perf_flushes)) perf_flushes <= perf_flushes + 32'd1;
    end
`else
    assign perf_stalls  = 32'h0;
    assign perf_flushes = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg. Two instances share stimulus: A uses the
// default counter (CNT_W=8, limit 200), B a narrow one (CNT_W=4, limit 10).
// A per-cycle model derived from the behavioural rules is compared on every
// falling edge; literal expectations at key points pin the model itself.
module tb_pipe_stage_reg;

    localparam logic [31:0] RV = 32'hA5A5_0001;
    localparam logic [31:0] FV = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b1;
    logic        clrBU = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] data_in = '0;

    logic [63:0] dout_a, dout_b;
    logic        vld_a, vld_b, to_a, to_b;
    logic [7:0]  st_a;
    logic [3:0]  st_b;
    logic [31:0] ps_a, pf_a, ps_b, pf_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .LANES(2), .RESET_VAL(RV), .FLUSH_VAL(FV),
                     .CNT_W(8), .STALL_LIMIT(200)) u_a (
        .clk(clk), .rst(rst), .enable(enable), .clrBU(clrBU), .in_valid(in_valid),
        .data_in(data_in), .data_out(dout_a), .out_valid(vld_a),
        .stall_cycles(st_a), .stall_timeout(to_a),
        .perf_stalls(ps_a), .perf_flushes(pf_a));

    pipe_stage_reg #(.DATA_W(32), .LANES(2), .RESET_VAL(RV), .FLUSH_VAL(FV),
                     .CNT_W(4), .STALL_LIMIT(10)) u_b (
        .clk(clk), .rst(rst), .enable(enable), .clrBU(clrBU), .in_valid(in_valid),
        .data_in(data_in), .data_out(dout_b), .out_valid(vld_b),
        .stall_cycles(st_b), .stall_timeout(to_b),
        .perf_stalls(ps_b), .perf_flushes(pf_b));

    // ---------------- behavioural model ----------------
    logic [31:0] m_d1 = RV, m_d0 = RV;
    bit          m_v  = 0;
    int          m_sa = 0, m_sb = 0;
    longint      m_ps = 0, m_pf = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_d1 = RV; m_d0 = RV; m_v = 0; m_sa = 0; m_sb = 0; m_ps = 0; m_pf = 0;
        end else if (clrBU) begin
            m_d1 = FV; m_d0 = FV; m_v = 0; m_sa = 0; m_sb = 0;
`ifdef PIPE_STAGE_PERF_EN
            if (m_pf < 64'hFFFF_FFFF) m_pf = m_pf + 1;
`endif
        end else if (!enable) begin
            if (in_valid) begin
                m_d1 = data_in[63:32]; m_d0 = data_in[31:0]; m_v = 1;
            end else begin
                m_d1 = FV; m_d0 = FV; m_v = 0;
            end
            m_sa = 0; m_sb = 0;
        end else if (m_v) begin
            m_sa = (m_sa < 255) ? m_sa + 1 : 255;
            m_sb = (m_sb < 15)  ? m_sb + 1 : 15;
`ifdef PIPE_STAGE_PERF_EN
            if (m_ps < 64'hFFFF_FFFF) m_ps = m_ps + 1;
`endif
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin
        chk("a.data_out", dout_a, {m_d1, m_d0});
        chk("b.data_out", dout_b, {m_d1, m_d0});
        chk("a.out_valid", 64'(vld_a), 64'(m_v));
        chk("b.out_valid", 64'(vld_b), 64'(m_v));
        chk("a.stall_cycles", 64'(st_a), 64'(m_sa));
        chk("b.stall_cycles", 64'(st_b), 64'(m_sb));
        chk("a.stall_timeout", 64'(to_a), 64'(m_sa >= 200));
        chk("b.stall_timeout", 64'(to_b), 64'(m_sb >= 10));
        chk("a.perf_stalls", 64'(ps_a), 64'(m_ps));
        chk("a.perf_flushes", 64'(pf_a), 64'(m_pf));
        chk("b.perf_stalls", 64'(ps_b), 64'(m_ps));
        chk("b.perf_flushes", 64'(pf_b), 64'(m_pf));
    end

    // Apply one cycle of inputs; returns just after the capturing edge.
    task automatic cyc(input logic en, input logic clr, input logic iv,
                       input logic [31:0] d1, input logic [31:0] d0);
        enable = en; clrBU = clr; in_valid = iv; data_in = {d1, d0};
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("lit.reset.data", dout_a, {RV, RV});
        chk("lit.reset.valid", 64'(vld_a), 64'd0);
        chk("lit.reset.stall", 64'(st_a), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Load, then stall 5 cycles with changing input data.
        cyc(1'b0, 1'b0, 1'b1, 32'h1234, 32'h0040);
        chk("lit.load.data", dout_a, {32'h1234, 32'h0040});
        chk("lit.load.valid", 64'(vld_a), 64'd1);
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 1'b1, 32'hF00 + k, 32'hBAD0 + k);
        chk("lit.hold.data", dout_a, {32'h1234, 32'h0040});
        chk("lit.hold.stall", 64'(st_a), 64'd5);
        chk("lit.hold.timeout", 64'(to_a), 64'd0);

        // Asynchronous reset mid-stall, observed before the next edge.
        #1 rst = 1'b1;
        #1;
        chk("lit.async.data", dout_a, {RV, RV});
        chk("lit.async.valid", 64'(vld_a), 64'd0);
        chk("lit.async.stall", 64'(st_a), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Perf counters: 3 stalls then 2 flushes from a clean reset.
        cyc(1'b0, 1'b0, 1'b1, 32'h1, 32'h2);
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
        for (int k = 0; k < 2; k++) cyc(1'b0, 1'b1, 1'b1, 32'h7, 32'h7);
`ifdef PIPE_STAGE_PERF_EN
        chk("lit.perf_stalls", 64'(ps_a), 64'd3);
        chk("lit.perf_flushes", 64'(pf_a), 64'd2);
`else
        chk("lit.perf_stalls", 64'(ps_a), 64'd0);
        chk("lit.perf_flushes", 64'(pf_a), 64'd0);
`endif
        chk("lit.flush.data", dout_a, {FV, FV});

        // Flush beats stall.
        cyc(1'b0, 1'b0, 1'b1, 32'hCAFE, 32'hBEEF);
        cyc(1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
        cyc(1'b1, 1'b1, 1'b1, 32'h0, 32'h0);
        chk("lit.flushstall.data", dout_a, {FV, FV});
        chk("lit.flushstall.valid", 64'(vld_a), 64'd0);
        chk("lit.flushstall.stall", 64'(st_a), 64'd0);

        // Bubble load, then holding a bubble is not a stall.
        cyc(1'b0, 1'b0, 1'b1, 32'h11, 32'h22);
        cyc(1'b0, 1'b0, 1'b0, 32'h33, 32'h44);
        chk("lit.bubble.data", dout_a, {FV, FV});
        chk("lit.bubble.valid", 64'(vld_a), 64'd0);
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("lit.bubblehold.stall", 64'(st_a), 64'd0);

        // Long stall: B times out at 10 and saturates at 15; A at 200 / 255.
        cyc(1'b0, 1'b0, 1'b1, 32'h5555, 32'hAAAA);
        for (int k = 1; k <= 260; k++) begin
            cyc(1'b1, 1'b0, 1'b1, 32'(k), 32'(k));
            if (k <= 20) begin
                chk("lit.b.stall", 64'(st_b), 64'((k < 15) ? k : 15));
                chk("lit.b.timeout", 64'(to_b), 64'(k >= 10));
            end
            if (k == 199) chk("lit.a.timeout199", 64'(to_a), 64'd0);
            if (k == 200) chk("lit.a.timeout200", 64'(to_a), 64'd1);
            if (k == 255) chk("lit.a.stall255", 64'(st_a), 64'd255);
        end
        chk("lit.a.sat", 64'(st_a), 64'd255);
        chk("lit.a.longhold.data", dout_a, {32'h5555, 32'hAAAA});

        // Reset during a flush.
        enable = 1'b1; clrBU = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("lit.rstflush.data", dout_a, {RV, RV});
        chk("lit.rstflush.stall", 64'(st_a), 64'd0);
        @(negedge clk);
        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
